// File: rtl/latency_mem_responder_if.sv
// Command/response bus between the CPU arbiter (master) and a memory responder (slave).
interface latency_mem_responder_if;
  logic        cmd_start;
  logic        cmd_write;
  logic        cmd_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] wmask;
  logic [31:0] rdata;
  logic        rdata_valid;

  modport master (output cmd_start, cmd_write, addr, wdata, wmask,
                  input  cmd_ready, rdata, rdata_valid);
  modport slave  (input  cmd_start, cmd_write, addr, wdata, wmask,
                  output cmd_ready, rdata, rdata_valid);
endinterface

// File: rtl/latency_mem_responder.sv
// Word RAM responder with programmable read latency and write recovery, one command
// outstanding; used to exercise the arbiter's memory stall paths.
module latency_mem_responder #(
  parameter int MEMORY_SIZE    = 4096,
  parameter     MEMORY_FILE    = "",
  parameter int READ_LATENCY   = 2,
  parameter int WRITE_RECOVERY = 1
) (
  input  logic clk,
  input  logic rst_n,
  latency_mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEMORY_SIZE);
  localparam logic [3:0] RL_M1 = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_M1 = 4'(WRITE_RECOVERY - 1);

  if (MEMORY_SIZE < 2 || (MEMORY_SIZE & (MEMORY_SIZE - 1)) != 0) begin : g_bad_size
    $error("latency_mem_responder: MEMORY_SIZE must be a power of two >= 2");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_rl
    $error("latency_mem_responder: READ_LATENCY must be 1..15");
  end
  if (WRITE_RECOVERY < 0 || WRITE_RECOVERY > 15) begin : g_bad_wr
    $error("latency_mem_responder: WRITE_RECOVERY must be 0..15");
  end

  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_BUSY} state_t;

  logic [31:0]   mem [MEMORY_SIZE];
  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] idx_q, idx_nx, idx_in;
  logic [31:0]   rdata_q;
  logic          resp, ready, accept;
  logic          unused_addr_bits;

  // Byte address -> word index; upper bits wrap modulo the depth.
  assign idx_in           = bus.addr[AW+1:2];
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // Ready overlaps the response cycle so the arbiter can chain its next command.
  assign resp   = (state == READ_WAIT) && (cnt == 4'd0);
  assign ready  = rst_n && ((state == IDLE) || resp);
  assign accept = bus.cmd_start && ready;

  assign bus.cmd_ready   = ready;
  assign bus.rdata_valid = resp;
  assign bus.rdata       = resp ? mem[idx_q] : rdata_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx_q;
    case (state)
      READ_WAIT, WRITE_BUSY: begin
        if (cnt != 4'd0) cnt_nx = cnt - 4'd1;
        else             state_nx = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      if (bus.cmd_write) begin
        if (WRITE_RECOVERY == 0) begin
          state_nx = IDLE;
          cnt_nx   = 4'd0;
        end else begin
          state_nx = WRITE_BUSY;
          cnt_nx   = WR_M1;
        end
      end else begin
        state_nx = READ_WAIT;
        cnt_nx   = RL_M1;
        idx_nx   = idx_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx_q <= idx_nx;
      if (resp) rdata_q <= mem[idx_q];
    end
  end

  // RAM contents survive reset; a write lands at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && bus.cmd_write)
      mem[idx_in] <= (mem[idx_in] & ~bus.wmask) | (bus.wdata & bus.wmask);
  end
endmodule

// File: tb/tb_latency_mem_responder.sv
// Directed bench: transaction-level model (memory map + response schedule) checked every
// cycle, plus literal expectations for latency, recovery, masking and reset behaviour.
module tb_latency_mem_responder;
  localparam int MS = 4096;
  localparam int RL = 3;
  localparam int WR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  latency_mem_responder_if bus();

  latency_mem_responder #(.MEMORY_SIZE(MS), .MEMORY_FILE(""), .READ_LATENCY(RL),
                          .WRITE_RECOVERY(WR))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] mmem [int];
  logic [31:0] hold = 32'h0;
  bit          pend = 1'b0;
  int          resp_cyc = 0;
  int          resp_idx = 0;
  int          ready_from = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MS);
  endfunction

  function automatic logic [31:0] mrd(input int i);
    return mmem.exists(i) ? mmem[i] : 32'h0;
  endfunction

  always @(posedge clk) begin
    int c;
    c = cyc;
    if (!rst_n) begin
      pend = 1'b0;
      hold = 32'h0;
      ready_from = 0;
    end else begin
      if (pend && c == resp_cyc) begin
        hold = mrd(resp_idx);
        pend = 1'b0;
      end
      if (bus.cmd_start && c >= ready_from) begin
        if (bus.cmd_write) begin
          mmem[widx(bus.addr)] = (mrd(widx(bus.addr)) & ~bus.wmask) | (bus.wdata & bus.wmask);
          ready_from = c + WR + 1;
        end else begin
          pend = 1'b1;
          resp_cyc = c + RL;
          resp_idx = widx(bus.addr);
          ready_from = c + RL;
        end
      end
    end
    cyc = c + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic ev, er;
    logic [31:0] ed;
    ev = rst_n && pend && (cyc == resp_cyc);
    er = rst_n && (cyc >= ready_from);
    ed = !rst_n ? 32'h0 : (ev ? mrd(resp_idx) : hold);
    check("cmd_ready", {31'h0, bus.cmd_ready}, {31'h0, er});
    check("rdata_valid", {31'h0, bus.rdata_valid}, {31'h0, ev});
    check("rdata", bus.rdata, ed);
  end

  // ---------------- stimulus ----------------
  task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] m, output int acc);
    bus.cmd_start = 1'b1; bus.cmd_write = w; bus.addr = a; bus.wdata = d; bus.wmask = m;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        #1 acc = cyc - 1;
        #1 bus.cmd_start = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'h0, 32'h1);
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_valid(input int acc, output int lat, output int low, output logic [31:0] d);
    lat = -1; low = 0; d = 32'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rdata_valid) begin
        lat = cyc - acc;
        d = bus.rdata;
        return;
      end
      if (!bus.cmd_ready) low++;
    end
    check("valid_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    int t1, t2, lat, low, nv;
    logic [31:0] d;
    bus.cmd_start = 1'b0; bus.cmd_write = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.wmask = 32'h0;

    // Reset state and release
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", {31'h0, bus.cmd_ready}, 32'h0);
    check("reset_valid", {31'h0, bus.rdata_valid}, 32'h0);
    check("reset_rdata", bus.rdata, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("release_ready", {31'h0, bus.cmd_ready}, 32'h1);

    // Read latency 3 after full-mask write
    do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, t1);
    do_cmd(1'b0, 32'h10, 32'h0, 32'h0, t1);
    wait_valid(t1, lat, low, d);
    check("read_latency", lat, RL);
    check("read_stall_cycles", low, RL - 1);
    check("read_data", d, 32'hDEADBEEF);

    // Masked write, and write recovery with the next command held
    do_cmd(1'b1, 32'h30, 32'h11223344, 32'hFFFFFFFF, t1);
    do_cmd(1'b1, 32'h30, 32'hAABBCCDD, 32'h0000FF00, t2);
    check("write_recovery_gap", t2 - t1, WR + 1);
    do_cmd(1'b0, 32'h30, 32'h0, 32'h0, t1);
    wait_valid(t1, lat, low, d);
    check("masked_data", d, 32'h1122CC44);

    // Write accepted in the rdata_valid cycle of a read
    do_cmd(1'b0, 32'h10, 32'h0, 32'h0, t1);
    do_cmd(1'b1, 32'h20, 32'h5A5A5A5A, 32'hFFFFFFFF, t2);
    check("b2b_accept_gap", t2 - t1, RL);
    do_cmd(1'b0, 32'h20, 32'h0, 32'h0, t1);
    wait_valid(t1, lat, low, d);
    check("b2b_data", d, 32'h5A5A5A5A);

    // Reset one cycle before the expected response
    do_cmd(1'b0, 32'h20, 32'h0, 32'h0, t1);
    @(posedge clk); #2 rst_n = 1'b0;
    nv = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rdata_valid) nv++;
    end
    check("dropped_response", nv, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rerelease_ready", {31'h0, bus.cmd_ready}, 32'h1);
    do_cmd(1'b0, 32'h4010, 32'h0, 32'h0, t1);
    wait_valid(t1, lat, low, d);
    check("wrap_data", d, 32'hDEADBEEF);

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
